// File: rtl/tick_interval_counter.sv
// tick_interval_counter
//   Measures elapsed time in 1 ms ticks between a Start and a Stop request and
//   presents it as packed BCD milliseconds. While measuring, TimerEn gates the
//   upstream 1 ms timer.
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst      in   asynchronous active-low reset
//   Tick     in   1 ms tick (single-cycle pulse expected)
//   Start    in   start / restart request
//   Stop     in   stop request
//   Clear    in   return to idle and zero the count
//   TimerEn  out  timer enable, high while running
//   Running  out  high while running
//   Done     out  high once stopped or saturated
//   Overflow out  count saturated at full scale
//   BcdOut   out  elapsed ms, packed BCD, digit 0 in [3:0]
module tick_interval_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Tick,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Clear,
  output logic                  TimerEn,
  output logic                  Running,
  output logic                  Done,
  output logic                  Overflow,
  output logic [4*DIGITS-1:0]   BcdOut
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StRunning, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   count_inc;
  logic           count_full;

  // Ripple BCD increment: each digit wraps 9 -> 0 and passes the carry up.
  always_comb begin
    logic carry;
    count_inc  = count_q;
    count_full = 1'b1;
    carry      = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (count_q[4*i +: 4] != 4'd9) begin
        count_full = 1'b0;
      end
      if (carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Priority: Clear > Stop > Start. Stop only has meaning while running.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (Clear) begin
      state_d = StIdle;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            state_d = StRunning;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        StRunning: begin
          // A tick on the same edge as Stop is counted before stopping.
          if (Tick) begin
            if (count_full) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              count_d = count_inc;
            end
          end
          if (Stop) begin
            state_d = StDone;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign TimerEn  = (state_q == StRunning);
  assign Running  = (state_q == StRunning);
  assign Done     = (state_q == StDone);
  assign Overflow = ovf_q;
  assign BcdOut   = count_q;

endmodule

// File: doc/tick_interval_counter.md
Name: tick_interval_counter

Overview:
Consumer end of the 1 ms tick interface. Gates the Timer_1ms block through its enable output, counts the returned 1 ms ticks between a Start and a Stop pulse, and presents the elapsed time as packed BCD milliseconds for the seven-segment display path. Provides the reaction-time measurement used by game logic.

Parameters:
DIGITS, 4, number of BCD digits in the count; full-scale value is 10^DIGITS - 1 (9999 at the default).

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Rst  input  1  asynchronous, active-low reset.
Tick  input  1  1 ms tick from Timer_1ms; nominally high for one Clk cycle.
Start  input  1  synchronous start/restart request, sampled each edge.
Stop  input  1  synchronous stop request, sampled each edge.
Clear  input  1  synchronous clear to idle, sampled each edge.
TimerEn  output  1  enable to Timer_1ms; high only while RUNNING.
Running  output  1  high in RUNNING.
Done  output  1  high in DONE.
Overflow  output  1  high when the count saturated at full scale.
BcdOut  output  4*DIGITS  elapsed milliseconds as packed BCD; digit 0 is at [3:0].

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE. BcdOut=0, TimerEn=0, Running=0, Done=0, Overflow=0. These values take effect immediately and hold while Rst=0, including when reset is asserted mid-RUNNING.
- All outputs are registered and decoded from state or count registers. There is no combinational input-to-output path.
- FSM states: IDLE, RUNNING, DONE. Inputs are evaluated each edge in priority order Clear > Stop > Start.
- Clear=1 in any state: next state IDLE, BcdOut=0, Overflow=0.
- IDLE:
  - Start=1: next state RUNNING; BcdOut cleared to 0; Overflow cleared.
  - Stop and Tick are ignored.
- RUNNING:
  - TimerEn=1 and Running=1 from the edge that enters the state.
  - Tick=1: BcdOut increments by 1 on that edge, so the new value is visible the next cycle.
  - BCD increment: digit 9 becomes 0 and carries into the next digit; no digit ever holds a value above 9.
  - Tick high for N consecutive cycles counts N times. The timer is required to deliver single-cycle pulses.
  - Tick=1 with the count at full scale (all digits 9): the count holds at full scale, Overflow=1, next state DONE.
  - Stop=1: next state DONE. If Tick=1 on the same edge, that tick is counted first.
  - Start=1 without Stop: ignored; counting continues.
- DONE:
  - Done=1, TimerEn=0, BcdOut frozen; Tick is ignored.
  - Start=1: next state RUNNING with BcdOut cleared to 0 and Overflow cleared.
  - Stop is ignored.
- Tick is ignored whenever the state is not RUNNING.
- Latency:
  - Start edge to TimerEn=1: 1 edge.
  - Tick edge to updated BcdOut: 1 edge.
  - Stop edge to Done=1: 1 edge.
- Running, Done and the IDLE state are mutually exclusive. Overflow=1 implies Done=1 unless a Clear or Start has since occurred.

Test Plan:
- Reset mid-count: Start, 5 ticks, assert Rst=0 between edges -> outputs go to 0 immediately without a clock edge; after release, state is IDLE and a Tick does not change BcdOut=0x0000.
- Basic measure: Start, 37 single-cycle ticks spaced 4 cycles apart, Stop -> BcdOut=0x0037, Done=1, TimerEn=0 one edge after Stop; 3 further ticks leave 0x0037.
- Digit carry: Start, 1000 ticks -> BcdOut passes through 0x0009, 0x0010, 0x0099, 0x0100, 0x0999 and ends at 0x1000; every nibble is 9 or less throughout.
- Saturation: Start, 10000 ticks -> BcdOut=0x9999, Overflow=1, Done=1 on the 10000th tick; further ticks have no effect.
- Simultaneous events: in RUNNING at 0x0012, assert Tick and Stop on the same edge -> BcdOut=0x0013, Done=1. Separately, assert Clear and Start on the same edge -> IDLE, BcdOut=0x0000.
- Restart from DONE: at BcdOut=0x0450 in DONE, pulse Start -> next cycle Running=1, BcdOut=0x0000, Overflow=0; 2 ticks -> BcdOut=0x0002.
